// File: rtl/counter_mod_updown.sv
// Run-time-programmable up/down modulo counter with synchronous clear/load,
// a combinational terminal count for cascading and a registered wrap pulse.
module counter_mod_updown #(
    parameter int CNT_WIDTH   = 8,
    parameter int DEFAULT_MOD = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 up_down,
    input  logic                 sync_clr,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 mod_we,
    input  logic [CNT_WIDTH-1:0] mod_in,
    output logic [CNT_WIDTH-1:0] counter_out,
    output logic [CNT_WIDTH-1:0] modulus_out,
    output logic                 tc,
    output logic                 wrap
);

    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ZERO      = '0;
    localparam logic [CNT_WIDTH-1:0] RESET_MOD = CNT_WIDTH'(DEFAULT_MOD);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] mod_q;
    logic [CNT_WIDTH-1:0] mod_last;
    logic                 wrap_q;
    logic                 wrap_d;
    logic                 at_top;
    logic                 at_zero;
    logic                 out_of_range;

    // The modulus register never holds a value below 2, so M-1 cannot underflow.
    assign mod_last     = mod_q - ONE;
    assign at_top       = (count_q == mod_last);
    assign at_zero      = (count_q == ZERO);
    assign out_of_range = (count_q > mod_last);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        wrap_d  = 1'b0;
        if (sync_clr) begin
            count_d = ZERO;
        end else if (load) begin
            count_d = (load_value < mod_q) ? load_value : mod_last;
        end else if (enable) begin
            if (up_down) begin
                if (at_top) begin
                    count_d = ZERO;
                    wrap_d  = 1'b1;
                end else if (out_of_range) begin
                    count_d = ZERO;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    count_d = mod_last;
                    wrap_d  = 1'b1;
                end else if (out_of_range) begin
                    count_d = mod_last;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            count_q <= ZERO;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Modulus writes bypass the counter priority chain; this cycle's step still uses the old M.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mod_q <= RESET_MOD;
        end else if (mod_we && (mod_in >= CNT_WIDTH'(2))) begin
            mod_q <= mod_in;
        end
    end

    assign tc          = enable & (up_down ? at_top : at_zero);
    assign counter_out = count_q;
    assign modulus_out = mod_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Self-checking bench for counter_mod_updown: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a modulo-arithmetic model.
module tb_counter_mod_updown;

    localparam int W    = 8;
    localparam int DMOD = 10;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic         up_down;
    logic         sync_clr;
    logic         load;
    logic [W-1:0] load_value;
    logic         mod_we;
    logic [W-1:0] mod_in;
    logic [W-1:0] counter_out;
    logic [W-1:0] modulus_out;
    logic         tc;
    logic         wrap;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    int m_cnt;
    int m_mod;
    bit m_wrap;

    counter_mod_updown #(.CNT_WIDTH(W), .DEFAULT_MOD(DMOD)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .up_down     (up_down),
        .sync_clr    (sync_clr),
        .load        (load),
        .load_value  (load_value),
        .mod_we      (mod_we),
        .mod_in      (mod_in),
        .counter_out (counter_out),
        .modulus_out (modulus_out),
        .tc          (tc),
        .wrap        (wrap)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model next count from plain modulo arithmetic over the current inputs.
    function automatic int next_count(int c, int m);
        if (sync_clr)           return 0;
        if (load)               return (int'(load_value) < m) ? int'(load_value) : m - 1;
        if (!enable)            return c;
        if (c >= m)             return up_down ? 0 : m - 1;
        if (up_down)            return (c + 1) % m;
        return (c + m - 1) % m;
    endfunction

    function automatic bit next_wrap(int c, int m);
        if (sync_clr || load || !enable || c >= m) return 1'b0;
        return up_down ? (c == m - 1) : (c == 0);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt  <= 0;
            m_mod  <= DMOD;
            m_wrap <= 1'b0;
        end else begin
            m_cnt  <= next_count(m_cnt, m_mod);
            m_wrap <= next_wrap(m_cnt, m_mod);
            if (mod_we && int'(mod_in) >= 2) m_mod <= int'(mod_in);
        end
    end

    // Single compare process: every cycle, mid-period, all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_counter", counter_out, m_cnt);
            check("model_modulus", modulus_out, m_mod);
            check("model_wrap", wrap, m_wrap);
            check("model_tc", tc, enable && (up_down ? (m_cnt == m_mod - 1) : (m_cnt == 0)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 0; up_down = 1; sync_clr = 0; load = 0;
        load_value = '0; mod_we = 0; mod_in = '0;
    endtask

    task automatic reset_pulse();
        reset_n = 0;
        #3;
        reset_n = 1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1;
        #2 reset_n = 0;
        #1;
        check("reset_counter", counter_out, 0);
        check("reset_modulus", modulus_out, 10);
        check("reset_wrap", wrap, 0);
        #10 reset_n = 1;
        cmp_en = 1;

        // Up count with default M=10.
        enable = 1; up_down = 1;
        step();
        check("up_first", counter_out, 1);
        for (int i = 2; i <= 21; i++) begin
            step();
            check("up_count", counter_out, i % 10);
            check("up_wrap", wrap, (i % 10) == 0);
            check("up_tc", tc, (i % 10) == 9);
        end

        // Down count from reset.
        @(posedge clk); #2;
        reset_pulse();
        up_down = 0;
        #1;
        check("down_tc_at_zero", tc, 1);
        for (int i = 1; i <= 12; i++) begin
            step();
            check("down_count", counter_out, (10 - i % 10) % 10);
            check("down_wrap", wrap, (i % 10) == 1);
        end

        // Priority chain.
        sync_clr = 1; load = 1; load_value = 5; enable = 1; up_down = 1;
        step();
        check("prio_clr", counter_out, 0);
        check("prio_clr_wrap", wrap, 0);
        sync_clr = 0;
        step();
        check("prio_load", counter_out, 5);
        check("prio_load_wrap", wrap, 0);
        load_value = 12;
        step();
        check("load_clamp", counter_out, 9);
        check("load_clamp_wrap", wrap, 0);

        // Modulus change while counting up, then down variant.
        load_value = 7;
        step();
        check("load7", counter_out, 7);
        load = 0; mod_we = 1; mod_in = 5;
        step();
        check("modchg_counter", counter_out, 8);
        check("modchg_modulus", modulus_out, 5);
        mod_we = 0;
        step();
        check("modchg_oor_up", counter_out, 0);
        check("modchg_oor_up_wrap", wrap, 0);
        enable = 0; mod_we = 1; mod_in = 10;
        step();
        mod_we = 0; load = 1; load_value = 8;
        step();
        check("load8", counter_out, 8);
        load = 0; enable = 1; up_down = 0; mod_we = 1; mod_in = 5;
        step();
        check("modchg_down_old_m", counter_out, 7);
        mod_we = 0;
        step();
        check("modchg_oor_down", counter_out, 4);
        check("modchg_oor_down_wrap", wrap, 0);

        // Illegal moduli are ignored; M=2 then toggles.
        enable = 0; mod_we = 1; mod_in = 0;
        step();
        check("illegal_mod0", modulus_out, 5);
        mod_in = 1;
        step();
        check("illegal_mod1", modulus_out, 5);
        mod_in = 2; sync_clr = 1;
        step();
        check("mod2_set", modulus_out, 2);
        check("mod2_clr", counter_out, 0);
        mod_we = 0; sync_clr = 0; enable = 1; up_down = 1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("mod2_count", counter_out, i % 2);
            check("mod2_wrap", wrap, (i % 2) == 0);
        end

        // Asynchronous reset mid-count at count 6, M=7.
        enable = 0; mod_we = 1; mod_in = 7; sync_clr = 1;
        step();
        mod_we = 0; sync_clr = 0; enable = 1; up_down = 1;
        repeat (6) step();
        check("pre_reset_count", counter_out, 6);
        check("pre_reset_tc", tc, 1);
        #2 reset_n = 0;
        #1;
        check("async_reset_counter", counter_out, 0);
        check("async_reset_modulus", modulus_out, 10);
        check("async_reset_wrap", wrap, 0);
        #1 reset_n = 1;
        step();
        check("post_reset_first", counter_out, 1);
        repeat (9) step();
        check("post_reset_wrap_cnt", counter_out, 0);
        check("post_reset_wrap", wrap, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            step();
            sync_clr   = ($urandom_range(0, 99) < 4);
            load       = ($urandom_range(0, 99) < 8);
            load_value = W'($urandom_range(0, 255));
            enable     = ($urandom_range(0, 99) < 75);
            up_down    = $urandom_range(0, 1);
            mod_we     = ($urandom_range(0, 99) < 5);
            mod_in     = $urandom_range(0, 1) ? W'($urandom_range(0, 20)) : W'($urandom_range(0, 255));
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 0;
                #3 reset_n = 1;
            end
        end

        step();
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
